// File: rtl/user_sig_reader_pkg.sv
// -----------------------------------------------------------------------------
// user_sig_reader_pkg
// Shared definitions for the user-domain signature reader:
//   - FSM state encoding
//   - OBI request/response structs used as the default bus types
//   - default expected chip signature, word-count limit, timeout length
//   - word-alignment helper for byte addresses
// Optional feature macro (used by the top): USER_SIG_READER_TIMEOUT_EN
// -----------------------------------------------------------------------------
package user_sig_reader_pkg;

    localparam int unsigned MaxWords        = 8;
    localparam int unsigned IdxWidth        = $clog2(MaxWords);

    localparam int unsigned ObiAddrWidth    = 32;
    localparam int unsigned ObiDataWidth    = 32;
    localparam int unsigned ObiIdWidth      = 4;

    localparam int unsigned TimeoutCycles   = 64;
    localparam int unsigned TimeoutCntWidth = $clog2(TimeoutCycles + 1);

    // Word 0 sits in the least significant 32 bits.
    localparam logic [3*32-1:0] DefaultSig = {32'h4349_5341, 32'h2073_2748, 32'h4926_434e};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [3:0]              be;
        logic [ObiDataWidth-1:0] wdata;
        logic [ObiIdWidth-1:0]   aid;
    } sig_obi_a_chan_t;

    typedef struct packed {
        sig_obi_a_chan_t a;
        logic            req;
        logic            rready;
    } sig_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } sig_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sig_obi_r_chan_t r;
    } sig_obi_rsp_t;

    // Byte address -> word-aligned byte address (bits [1:0] forced to zero).
    function automatic logic [ObiAddrWidth-1:0] word_align(input logic [ObiAddrWidth-1:0] addr);
        word_align = {addr[ObiAddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/user_sig_timeout.sv
// -----------------------------------------------------------------------------
// user_sig_timeout
// Watchdog counter for the signature reader, only instantiated when
// USER_SIG_READER_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart the count (asserted on every FSM state change)
//   run_i         : count while the reader waits on the bus (REQ / WAIT)
//   expired_o     : high in the TimeoutCycles-th cycle spent in one state
// -----------------------------------------------------------------------------
module user_sig_timeout
    import user_sig_reader_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    logic [TimeoutCntWidth-1:0] cnt_r;

    // The count is 0 in the first cycle of a state, so expiry is flagged at
    // TimeoutCycles-1; the FSM then leaves exactly TimeoutCycles after entry.
    assign expired_o = run_i && (cnt_r == TimeoutCntWidth'(TimeoutCycles - 1));

    // Cycle counter, restarted on each state entry and frozen once expired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (run_i && !expired_o) begin
            cnt_r <= cnt_r + TimeoutCntWidth'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/user_sig_reader.sv
// -----------------------------------------------------------------------------
// user_sig_reader
// OBI manager that, on start_i, reads NumWords consecutive 32-bit words from
// base_addr_i (one outstanding transaction at a time), captures them on
// data_o and compares them against ExpectedSig.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : single-cycle start pulse (ignored while busy)
//   base_addr_i    : byte address of word 0, bits [1:0] ignored
//   busy_o         : sequence in progress (REQ / WAIT / DONE)
//   done_o         : one-cycle pulse at the end of a sequence
//   err_o          : sticky, response error or ID mismatch in last sequence
//   match_o        : sticky, all words equal ExpectedSig and no error
//   data_o         : captured words, word i at [32i+31:32i]
//   obi_req_o      : OBI A channel + rready (rready tied high)
//   obi_rsp_i      : OBI gnt + R channel
// Optional feature: define USER_SIG_READER_TIMEOUT_EN to abort a sequence
// with err_o=1 after TimeoutCycles cycles stuck in REQ or WAIT.
// -----------------------------------------------------------------------------
module user_sig_reader
    import user_sig_reader_pkg::*;
#(
    parameter type                    obi_req_t   = user_sig_reader_pkg::sig_obi_req_t,
    parameter type                    obi_rsp_t   = user_sig_reader_pkg::sig_obi_rsp_t,
    parameter int unsigned            NumWords    = 3,
    parameter logic [NumWords*32-1:0] ExpectedSig = DefaultSig
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ObiAddrWidth-1:0]  base_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     match_o,
    output logic [NumWords*32-1:0]   data_o,
    output obi_req_t                 obi_req_o,
    input  obi_rsp_t                 obi_rsp_i
);

    state_e                  state_r, state_next_s;
    logic [IdxWidth-1:0]     idx_r;
    logic [ObiAddrWidth-1:0] addr_r;
    logic [NumWords*32-1:0]  data_r, data_next_s;
    logic                    err_r, err_next_s;
    logic                    match_r, match_next_s;
    logic                    busy_r, done_r, req_r;

    logic                    start_seq_s;
    logic                    capture_s;
    logic                    advance_s;
    logic                    timeout_s;
    logic                    last_word_s;
    logic                    tmo_expired_s;

    assign last_word_s = (idx_r == IdxWidth'(NumWords - 1));

`ifdef USER_SIG_READER_TIMEOUT_EN
    logic tmo_run_s;
    logic tmo_clear_s;

    assign tmo_run_s   = (state_r == REQ) || (state_r == WAIT);
    assign tmo_clear_s = (state_next_s != state_r);

    user_sig_timeout u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (tmo_clear_s),
        .run_i     (tmo_run_s),
        .expired_o (tmo_expired_s)
    );
`else
    assign tmo_expired_s = 1'b0;
`endif

    // Next-state decode; a timeout takes precedence over a same-cycle handshake.
    always_comb begin
        state_next_s = state_r;
        start_seq_s  = 1'b0;
        capture_s    = 1'b0;
        advance_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = REQ;
                    start_seq_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                // A response showing up here cannot belong to this request.
                if (tmo_expired_s) begin
                    state_next_s = DONE;
                    timeout_s    = 1'b1;
                end else if (obi_rsp_i.gnt) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (tmo_expired_s) begin
                    state_next_s = DONE;
                    timeout_s    = 1'b1;
                end else if (obi_rsp_i.rvalid) begin
                    capture_s = 1'b1;
                    if (last_word_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = REQ;
                        advance_s    = 1'b1;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Capture path: clear on start, write word idx and accumulate errors on a response.
    always_comb begin
        data_next_s = data_r;
        err_next_s  = err_r;
        if (start_seq_s) begin
            data_next_s = '0;
            err_next_s  = 1'b0;
        end else if (capture_s) begin
            for (int unsigned w = 0; w < NumWords; w++) begin
                if (idx_r == IdxWidth'(w)) begin
                    data_next_s[w*32 +: 32] = obi_rsp_i.r.rdata;
                end else begin
                    data_next_s[w*32 +: 32] = data_r[w*32 +: 32];
                end
            end
            if (obi_rsp_i.r.err || (obi_rsp_i.r.rid != ObiIdWidth'(idx_r))) begin
                err_next_s = 1'b1;
            end else begin
                err_next_s = err_r;
            end
        end else if (timeout_s) begin
            err_next_s = 1'b1;
        end else begin
            data_next_s = data_r;
            err_next_s  = err_r;
        end
    end

    // Match is evaluated on DONE entry using the word captured in that same cycle.
    always_comb begin
        match_next_s = match_r;
        if (start_seq_s) begin
            match_next_s = 1'b0;
        end else if ((state_next_s == DONE) && (state_r != DONE)) begin
            match_next_s = (data_next_s == ExpectedSig) && !err_next_s && !timeout_s;
        end else begin
            match_next_s = match_r;
        end
    end

    // State, datapath and registered status/handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            idx_r   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
            match_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            data_r  <= data_next_s;
            err_r   <= err_next_s;
            match_r <= match_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            req_r   <= (state_next_s == REQ);
            if (start_seq_s) begin
                addr_r <= word_align(base_addr_i);
                idx_r  <= '0;
            end else if (advance_s) begin
                // Plain modulo-2^AddrWidth addition gives the required wrap.
                addr_r <= addr_r + ObiAddrWidth'(32'd4);
                idx_r  <= idx_r + IdxWidth'(1'b1);
            end else begin
                addr_r <= addr_r;
                idx_r  <= idx_r;
            end
        end
    end

    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign err_o   = err_r;
    assign match_o = match_r;
    assign data_o  = data_r;

    // Read-only manager: constant write fields, all A-channel fields from flops.
    always_comb begin
        obi_req_o         = '0;
        obi_req_o.req     = req_r;
        obi_req_o.rready  = 1'b1;
        obi_req_o.a.addr  = addr_r;
        obi_req_o.a.we    = 1'b0;
        obi_req_o.a.be    = 4'hF;
        obi_req_o.a.wdata = '0;
        obi_req_o.a.aid   = ObiIdWidth'(idx_r);
    end

endmodule

// File: tb/tb_user_sig_reader.sv
// -----------------------------------------------------------------------------
// tb_user_sig_reader
// Drives user_sig_reader against a ROM-like OBI subordinate (2-cycle response
// latency, optional grant stall, error injection, mute) and checks results
// from a table of vectors plus hand-written reset sequences. A second
// instance with word 0 of its expected signature set to zero shares the bus
// responses and runs in lockstep to check the compare against ExpectedSig.
// -----------------------------------------------------------------------------
module tb_user_sig_reader;
    import user_sig_reader_pkg::*;

    localparam int unsigned NW     = 3;
    localparam int          BUDGET = 200;
    localparam logic [31:0] SIG0   = 32'h4926_434e;
    localparam logic [31:0] SIG1   = 32'h2073_2748;
    localparam logic [31:0] SIG2   = 32'h4349_5341;
    localparam logic [95:0] NOMINAL_DATA = {SIG2, SIG1, SIG0};
    localparam logic [95:0] ALT_SIG      = {SIG2, SIG1, 32'h0000_0000};

    typedef struct {
        string       name;
        logic [31:0] base;
        int          stall_word;
        int          stall_cycles;
        logic        err_en;
        logic [31:0] err_addr;
        int          restart_at;
        logic        mute;
        int          exp_hs;
        logic [95:0] exp_data;
        logic        exp_err;
        logic        exp_match;
        logic        exp_match_alt;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [95:0] data;
        logic        err;
        logic        match;
        logic        match_alt;
        int          lat;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  aid;
    } exp_a_t;

    logic        clk       = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] base_addr = 32'h0;

    logic        busy, done, err, match;
    logic [95:0] data;
    logic        busy_alt, done_alt, err_alt, match_alt;
    logic [95:0] data_alt;
    sig_obi_req_t obi_req, obi_req_alt;
    sig_obi_rsp_t obi_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    user_sig_reader #(
        .obi_req_t   (sig_obi_req_t),
        .obi_rsp_t   (sig_obi_rsp_t),
        .NumWords    (NW),
        .ExpectedSig (NOMINAL_DATA)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .base_addr_i (base_addr),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .match_o     (match),
        .data_o      (data),
        .obi_req_o   (obi_req),
        .obi_rsp_i   (obi_rsp)
    );

    user_sig_reader #(
        .obi_req_t   (sig_obi_req_t),
        .obi_rsp_t   (sig_obi_rsp_t),
        .NumWords    (NW),
        .ExpectedSig (ALT_SIG)
    ) dut_alt (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .base_addr_i (base_addr),
        .busy_o      (busy_alt),
        .done_o      (done_alt),
        .err_o       (err_alt),
        .match_o     (match_alt),
        .data_o      (data_alt),
        .obi_req_o   (obi_req_alt),
        .obi_rsp_i   (obi_rsp)
    );

    always #5 clk = ~clk;

    // ---------------- subordinate model ----------------
    logic [31:0] rom [16];
    int          stall_word   = -1;
    int          stall_cycles = 0;
    int          stall_cnt    = 0;
    logic        err_en       = 1'b0;
    logic [31:0] err_addr     = 32'h0;
    logic        mute         = 1'b0;
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_addr = 32'h0, p2_addr = 32'h0;
    logic [3:0]  p1_id = 4'h0, p2_id = 4'h0;
    logic        stalling;

    assign stalling = (stall_word >= 0) && (int'(obi_req.a.aid) == stall_word)
                      && (stall_cnt < stall_cycles);

    // Grant and 2-cycle response channel of the ROM.
    always_comb begin
        obi_rsp         = '0;
        obi_rsp.gnt     = obi_req.req && !stalling;
        obi_rsp.rvalid  = p2_v && !mute;
        obi_rsp.r.rdata = rom[p2_addr[5:2]];
        obi_rsp.r.rid   = p2_id;
        obi_rsp.r.err   = p2_v && err_en && (p2_addr == err_addr);
    end

    // Response pipeline and grant-stall counter.
    always @(posedge clk) begin
        if (start) stall_cnt <= 0;
        else if (obi_req.req && stalling) stall_cnt <= stall_cnt + 1;
        p1_v    <= obi_req.req && obi_rsp.gnt;
        p1_addr <= obi_req.a.addr;
        p1_id   <= obi_req.a.aid;
        p2_v    <= p1_v;
        p2_addr <= p1_addr;
        p2_id   <= p1_id;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    res_t   res_q[$];
    exp_a_t exp_a_q[$];

    task automatic run_vec(input vec_t v);
        int           lat;
        int           hs;
        logic         prev_stall;
        sig_obi_req_t prev_req;
        logic [31:0]  base_al;
        res_t         r;
        exp_a_t       e;
        stall_word   = v.stall_word;
        stall_cycles = v.stall_cycles;
        err_en       = v.err_en;
        err_addr     = v.err_addr;
        mute         = v.mute;
        base_al      = v.base & 32'hFFFF_FFFC;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        for (int i = 0; i < v.exp_hs; i++) begin
            exp_a_q.push_back('{addr: base_al + 32'(i) * 32'd4, aid: 4'(i)});
        end
        res_q.push_back('{data: v.exp_data, err: v.exp_err, match: v.exp_match,
                          match_alt: v.exp_match_alt, lat: v.exp_lat});
        @(negedge clk);
        start     = 1'b0;
        base_addr = ~v.base;
        lat = 0; hs = 0; prev_stall = 1'b0; prev_req = '0;
        for (int c = 1; c <= BUDGET; c++) begin
            start = (c == v.restart_at);
            if (prev_stall)
                check({v.name, "/stall_hold"}, {obi_req.req, obi_req.a}, {1'b1, prev_req.a});
            if (obi_req.req && obi_rsp.gnt) begin
                hs++;
                if (exp_a_q.size() > 0) begin
                    e = exp_a_q.pop_front();
                    check({v.name, "/a_chan"},
                          {obi_req.a.addr, obi_req.a.aid, obi_req.a.be, obi_req.a.we, obi_req.a.wdata, obi_req.rready},
                          {e.addr, e.aid, 4'hF, 1'b0, 32'h0, 1'b1});
                end else begin
                    check({v.name, "/extra_handshake"}, hs, v.exp_hs);
                end
            end
            prev_stall = obi_req.req && !obi_rsp.gnt;
            prev_req   = obi_req;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (lat == 0) check({v.name, "/done_seen"}, done, 1'b1);
        r = res_q.pop_front();
        check({v.name, "/latency"}, lat, r.lat);
        check({v.name, "/data"}, data, r.data);
        check({v.name, "/err_match"}, {err, match}, {r.err, r.match});
        check({v.name, "/alt_match"}, {done_alt, match_alt}, {1'b1, r.match_alt});
        check({v.name, "/handshakes"}, hs, v.exp_hs);
        exp_a_q.delete();
        repeat (3) @(negedge clk);
        check({v.name, "/idle_after"}, {busy, done, obi_req.req}, 3'b000);
        check({v.name, "/sticky"}, {err, match, data}, {r.err, r.match, r.data});
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 16; i++) rom[i] = 32'hA5A5_0000 | 32'(i);
        rom[0] = SIG0; rom[1] = SIG1; rom[2] = SIG2;
        rom[4] = 32'h0000_0000; rom[5] = SIG1; rom[6] = SIG2;

        //          name        base          stw sc err   eaddr       rst mute hs data                                  err  match alt  lat
        vecs.push_back('{"nominal", 32'h0000_0000, -1, 0, 1'b0, 32'h0, 0, 1'b0, 3, NOMINAL_DATA, 1'b0, 1'b1, 1'b0, 10});
        vecs.push_back('{"gnt_stall", 32'h0000_0000, 1, 3, 1'b0, 32'h0, 0, 1'b0, 3, NOMINAL_DATA, 1'b0, 1'b1, 1'b0, 13});
        vecs.push_back('{"r_err_w2", 32'h0000_0000, -1, 0, 1'b1, 32'h8, 0, 1'b0, 3, NOMINAL_DATA, 1'b1, 1'b0, 1'b0, 10});
        vecs.push_back('{"restart_busy", 32'h0000_0000, -1, 0, 1'b0, 32'h0, 4, 1'b0, 3, NOMINAL_DATA, 1'b0, 1'b1, 1'b0, 10});
        vecs.push_back('{"unaligned", 32'h0000_0013, -1, 0, 1'b0, 32'h0, 0, 1'b0, 3, ALT_SIG, 1'b0, 1'b0, 1'b1, 10});
        vecs.push_back('{"addr_wrap", 32'hFFFF_FFF8, -1, 0, 1'b0, 32'h0, 0, 1'b0, 3,
                         {SIG0, 32'hA5A5_000F, 32'hA5A5_000E}, 1'b0, 1'b0, 1'b0, 10});
`ifdef USER_SIG_READER_TIMEOUT_EN
        vecs.push_back('{"timeout", 32'h0000_0000, -1, 0, 1'b0, 32'h0, 0, 1'b1, 1, 96'h0, 1'b1, 1'b0, 1'b0, 66});
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, err, match, data, obi_req.req}, '0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset while waiting for word 1, then a fresh sequence.
        stall_word = -1; err_en = 1'b0; mute = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (obi_req.req && obi_rsp.gnt && (obi_req.a.aid == 4'd1)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid/reached_word1", found, 1'b1);
        @(negedge clk);
        check("rst_mid/in_wait", {busy, obi_req.req}, 2'b10);
        #2 rst_ni = 1'b0;
        #1 check("rst_mid/outputs", {busy, done, err, match, data, obi_req.req}, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid/stale_ignored", {busy, done, data, obi_req.req}, '0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
